// File: rtl/opl3_write_sequencer_pkg.sv
// Shared state encoding and constants for the OPL3 register-write sequencer.
package opl3_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_WE,
    ADDR_GAP,
    DATA_WE,
    DATA_GAP
  } seq_state_t;

  localparam logic OPL_A0_INDEX = 1'b0;
  localparam logic OPL_A0_DATA  = 1'b1;

  localparam int WE_CYCLES_MIN  = 1;
  localparam int WE_CYCLES_MAX  = 255;
  localparam int GAP_CYCLES_MIN = 2;
  localparam int GAP_CYCLES_MAX = 255;

endpackage

// File: rtl/opl3_write_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last time takes a tie.
module opl3_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant,
  output logic any_valid,
  output logic last_grant
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/opl3_write_sequencer.sv
// Paces arbitrated register writes onto the OPL3 host bus as an index write
// followed by a data write, with spaced we pulses and held addr/din.
module opl3_write_sequencer
  import opl3_seq_pkg::*;
#(
  parameter int WE_CYCLES  = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [8:0] req0_index,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_index,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [1:0] opl_addr,
  output logic [7:0] opl_din,
  output logic       opl_we,
  output logic       busy,
  output logic       last_grant
);

  if (WE_CYCLES < WE_CYCLES_MIN || WE_CYCLES > WE_CYCLES_MAX) begin : g_bad_we_cycles
    $error("opl3_write_sequencer: WE_CYCLES=%0d out of range", WE_CYCLES);
  end
  if (GAP_CYCLES < GAP_CYCLES_MIN || GAP_CYCLES > GAP_CYCLES_MAX) begin : g_bad_gap_cycles
    $error("opl3_write_sequencer: GAP_CYCLES=%0d out of range", GAP_CYCLES);
  end

  localparam logic [7:0] WE_LOAD  = 8'(WE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  seq_state_t state;
  logic [7:0] cnt;
  logic       bank_q;
  logic [7:0] data_q;
  logic       grant;
  logic       any_valid;
  logic       accept;
  logic [8:0] win_index;
  logic [7:0] win_data;

  opl3_rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .accept     (accept),
    .grant      (grant),
    .any_valid  (any_valid),
    .last_grant (last_grant)
  );

  // Gating with rst_n keeps both ready strobes low while reset is held.
  assign accept     = rst_n && (state == IDLE) && any_valid;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign win_index  = grant ? req1_index : req0_index;
  assign win_data   = grant ? req1_data : req0_data;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      bank_q   <= 1'b0;
      data_q   <= 8'd0;
      opl_we   <= 1'b0;
      opl_addr <= 2'b00;
      opl_din  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= ADDR_WE;
            cnt      <= WE_LOAD;
            bank_q   <= win_index[8];
            data_q   <= win_data;
            opl_we   <= 1'b1;
            opl_addr <= {win_index[8], OPL_A0_INDEX};
            opl_din  <= win_index[7:0];
          end
        end
        ADDR_WE: begin
          if (cnt == 8'd0) begin
            state  <= ADDR_GAP;
            cnt    <= GAP_LOAD;
            opl_we <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // Bus values only move on the cycle we rises, never on its falling edge.
        ADDR_GAP: begin
          if (cnt == 8'd0) begin
            state    <= DATA_WE;
            cnt      <= WE_LOAD;
            opl_we   <= 1'b1;
            opl_addr <= {bank_q, OPL_A0_DATA};
            opl_din  <= data_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DATA_WE: begin
          if (cnt == 8'd0) begin
            state  <= DATA_GAP;
            cnt    <= GAP_LOAD;
            opl_we <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DATA_GAP: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          opl_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opl3_write_sequencer.sv
// Randomized bench for opl3_write_sequencer against a transaction-timeline model,
// plus a directed check of a WE_CYCLES=1 / GAP_CYCLES=2 instance.
module tb_opl3_write_sequencer;

  localparam int W   = 4;
  localparam int G   = 8;
  localparam int TXN = 2 * (W + G);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [8:0] req0_index = '0, req1_index = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, opl_we, busy, last_grant;
  logic [1:0] opl_addr;
  logic [7:0] opl_din;

  logic       c_req0_valid = 1'b0, c_req1_valid = 1'b0;
  logic [8:0] c_req0_index = '0, c_req1_index = '0;
  logic [7:0] c_req0_data = '0, c_req1_data = '0;
  logic       c_req0_ready, c_req1_ready, c_opl_we, c_busy, c_last_grant;
  logic [1:0] c_opl_addr;
  logic [7:0] c_opl_din;

  opl3_write_sequencer #(.WE_CYCLES(W), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_index(req0_index), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_index(req1_index), .req1_data(req1_data), .req1_ready(req1_ready),
    .opl_addr(opl_addr), .opl_din(opl_din), .opl_we(opl_we), .busy(busy), .last_grant(last_grant)
  );

  opl3_write_sequencer #(.WE_CYCLES(1), .GAP_CYCLES(2)) dut_corner (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(c_req0_valid), .req0_index(c_req0_index), .req0_data(c_req0_data), .req0_ready(c_req0_ready),
    .req1_valid(c_req1_valid), .req1_index(c_req1_index), .req1_data(c_req1_data), .req1_ready(c_req1_ready),
    .opl_addr(c_opl_addr), .opl_din(c_opl_din), .opl_we(c_opl_we), .busy(c_busy), .last_grant(c_last_grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rel_cyc = 0;

  // Model: one transaction timeline anchored at its accept cycle.
  bit         m_active = 0;
  int         m_t = 0;
  logic [8:0] m_idx = '0;
  logic [7:0] m_dat = '0;
  logic [1:0] m_addr = '0;
  logic [7:0] m_din = '0;
  logic       m_lg = 1'b1;
  bit         hs0 = 0, hs1 = 0;
  int         dut_g[$];
  int         dut_c[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_active = 0;
    m_lg     = 1'b1;
    m_addr   = '0;
    m_din    = '0;
  endtask

  task automatic modelCheck();
    int off;
    bit in_txn, e_we, e_r0, e_r1, win;
    off    = cyc - m_t;
    in_txn = m_active && off >= 1 && off <= TXN;
    e_we   = 0;
    if (in_txn) begin
      if (off <= W + G) begin
        m_addr = {m_idx[8], 1'b0};
        m_din  = m_idx[7:0];
        e_we   = (off <= W);
      end else begin
        m_addr = {m_idx[8], 1'b1};
        m_din  = m_dat;
        e_we   = (off <= 2 * W + G);
      end
    end
    e_r0 = 0;
    e_r1 = 0;
    if (rst_n && !in_txn && (req0_valid || req1_valid)) begin
      win  = (req0_valid && req1_valid) ? !m_lg : req1_valid;
      e_r0 = !win;
      e_r1 = win;
    end
    checkOutput("ready0", req0_ready, e_r0);
    checkOutput("ready1", req1_ready, e_r1);
    checkOutput("busy", busy, in_txn);
    checkOutput("we", opl_we, e_we);
    checkOutput("addr", opl_addr, m_addr);
    checkOutput("din", opl_din, m_din);
    checkOutput("last_grant", last_grant, m_lg);
    if (req0_ready) begin dut_g.push_back(0); dut_c.push_back(cyc); end
    if (req1_ready) begin dut_g.push_back(1); dut_c.push_back(cyc); end
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (e_r0 || e_r1) begin
      m_active = 1;
      m_t      = cyc;
      m_idx    = e_r1 ? req1_index : req0_index;
      m_dat    = e_r1 ? req1_data : req0_data;
      m_lg     = e_r1;
    end
  endtask

  // mode 0: random requesters, 1: both always valid, 2: hold, drop after accept.
  task automatic applyStimulus(input int mode);
    if (hs0) begin
      req0_index = 9'($urandom_range(0, 511));
      req0_data  = mode == 2 ? 8'hFF : 8'($urandom_range(0, 255));
      req0_valid = (mode == 1) || (mode == 0 && $urandom_range(0, 3) != 0);
    end else if (mode == 0 && !req0_valid && $urandom_range(0, 7) == 0) begin
      req0_index = 9'($urandom_range(0, 511));
      req0_data  = 8'($urandom_range(0, 255));
      req0_valid = 1'b1;
    end
    if (hs1) begin
      req1_index = 9'($urandom_range(0, 511));
      req1_data  = mode == 2 ? 8'hFF : 8'($urandom_range(0, 255));
      req1_valid = (mode == 1) || (mode == 0 && $urandom_range(0, 3) != 0);
    end else if (mode == 0 && !req1_valid && $urandom_range(0, 7) == 0) begin
      req1_index = 9'($urandom_range(0, 511));
      req1_data  = 8'($urandom_range(0, 255));
      req1_valid = 1'b1;
    end
    hs0 = 0;
    hs1 = 0;
  endtask

  task automatic stepCycle(input int mode);
    @(posedge clk);
    cyc++;
    #1;
    applyStimulus(mode);
    @(negedge clk);
    modelCheck();
  endtask

  task automatic loadReq(input bit v0, input logic [8:0] i0, input logic [7:0] d0,
                         input bit v1, input logic [8:0] i1, input logic [7:0] d1);
    @(posedge clk);
    cyc++;
    #1;
    req0_valid = v0; req0_index = i0; req0_data = d0;
    req1_valid = v1; req1_index = i1; req1_data = d1;
    hs0 = 0;
    hs1 = 0;
    @(negedge clk);
    modelCheck();
  endtask

  task automatic doReset(input int mode);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", opl_we, 0);
    checkOutput("rst_addr", opl_addr, 0);
    checkOutput("rst_din", opl_din, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", {req1_ready, req0_ready}, 0);
    checkOutput("rst_last_grant", last_grant, 1);
    checkOutput("rst_c_we", c_opl_we, 0);
    modelReset();
    for (int i = 0; i < 2; i++) stepCycle(mode);
    @(posedge clk);
    cyc++;
    #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    applyStimulus(mode);
    @(negedge clk);
    modelCheck();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    int n0;
    int t_acc;

    // Tie from reset: grants must alternate and be spaced by one transaction period.
    req0_valid = 1; req0_index = 9'h011; req0_data = 8'h22;
    req1_valid = 1; req1_index = 9'h133; req1_data = 8'h44;
    #2;
    doReset(1);
    for (int i = 0; i < 4 * (TXN + 1) + 4; i++) stepCycle(1);
    checkOutput("tie_count_ok", dut_g.size() >= 4, 1);
    if (dut_g.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("tie_order", dut_g[i], i % 2);
      for (int i = 1; i < 4; i++) checkOutput("tie_spacing", dut_c[i] - dut_c[i-1], TXN + 1);
      checkOutput("tie_first_accept", dut_c[0], rel_cyc);
    end

    // Reset while the data write strobe is high.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      stepCycle(1);
      if (m_active && (cyc - m_t) > W + G + 1 && (cyc - m_t) <= 2 * W + G) found = 1;
    end
    checkOutput("reach_data_we", found, 1);
    #2;
    n0 = dut_g.size();
    doReset(1);
    stepCycle(1);
    checkOutput("post_rst_accept", dut_g.size() > n0, 1);
    if (dut_g.size() > n0) begin
      checkOutput("post_rst_winner", dut_g[n0], 0);
      checkOutput("post_rst_latency", dut_c[n0] - rel_cyc <= 1, 1);
    end

    // Single write, input stability, then a bank-1 write.
    loadReq(0, 9'h000, 8'h00, 0, 9'h000, 8'h00);
    for (int i = 0; i < TXN + 2; i++) stepCycle(2);
    loadReq(1, 9'h0A4, 8'h57, 0, 9'h000, 8'h00);
    for (int i = 0; i < TXN + 3; i++) stepCycle(2);
    loadReq(1, 9'h105, 8'h01, 0, 9'h000, 8'h00);
    for (int i = 0; i < TXN + 3; i++) stepCycle(2);

    // Random traffic.
    for (int i = 0; i < 900; i++) stepCycle(0);
    loadReq(0, 9'h000, 8'h00, 0, 9'h000, 8'h00);
    for (int i = 0; i < TXN + 2; i++) stepCycle(2);

    // Minimum-timing instance: 1-cycle we pulses, 7-cycle period, timer preset index 2.
    @(posedge clk);
    #1;
    c_req0_index = 9'h002; c_req0_data = 8'h5A; c_req0_valid = 1'b1;
    found = 0;
    t_acc = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (c_req0_ready) found = 1;
    end
    checkOutput("c_accept", found, 1);
    if (found) begin
      for (int k = 1; k <= 7; k++) begin
        @(posedge clk);
        #1;
        if (k == 1) c_req0_data = 8'h33;
        @(negedge clk);
        checkOutput("c_we", c_opl_we, (k == 1 || k == 4));
        checkOutput("c_busy", c_busy, k <= 6);
        checkOutput("c_ready", c_req0_ready, k == 7);
        checkOutput("c_addr", c_opl_addr, k <= 3 ? 2'b00 : 2'b01);
        checkOutput("c_din", c_opl_din, k <= 3 ? 8'h02 : 8'h5A);
        if (k == 1) checkOutput("c_last_grant", c_last_grant, 0);
      end
    end
    @(posedge clk);
    #1;
    c_req0_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opl3_write_sequencer.md
# opl3_write_sequencer

Arbitrates between two register-write requesters and drives the OPL3 wrapper's host bus (`addr`, `din`, `we`) as a paced index-write / data-write pair. Requester 0 is normally the Z80 I/O port decoder and requester 1 the register-restore engine. The block sits between those requesters and the `opl3` instance on the same `clk`. It guarantees that `we` edges are spaced so the wrapper's edge detector sees every write. It also holds `addr`/`din` stable across the falling edge of `we`, which the mono-forcing logic samples.

## Interface
- `WE_CYCLES`, default 4: cycles `opl_we` stays high per phase; legal range 1..255.
- `GAP_CYCLES`, default 8: cycles `opl_we` stays low after each phase, with `addr`/`din` held; legal range 2..255.
- `clk` input, 1 bit: system clock, same clock as the `opl3` `clk`.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req0_valid` input, 1 bit: requester 0 has a write pending.
- `req0_index` input, 9 bits: register index; bit 8 selects the bank (high array).
- `req0_data` input, 8 bits: register data.
- `req0_ready` output, 1 bit: accept strobe for requester 0.
- `req1_valid`, `req1_index`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `opl_addr` output, 2 bits: to `opl3.addr`; bit 1 is bank, bit 0 is data/index.
- `opl_din` output, 8 bits: to `opl3.din`.
- `opl_we` output, 1 bit: to `opl3.we`.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `last_grant` output, 1 bit: ID of the most recently accepted requester.

## Operation
- **Handshake:** a transfer completes in the cycle where `reqN_valid && reqN_ready`. `reqN_ready` is a single-cycle pulse, asserted only in IDLE and only to the arbitration winner. Requesters hold `valid`/`index`/`data` until they see `ready`.
- **Arbitration:** round-robin over two requesters. When both are valid in IDLE, the requester not equal to `last_grant` wins. When only one is valid, it wins. Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- **Capture:** on acceptance, `index` and `data` are latched internally. Later changes on the requester inputs have no effect on the transaction.
- **FSM states:** IDLE, ADDR_WE, ADDR_GAP, DATA_WE, DATA_GAP.
  - IDLE → ADDR_WE on accept.
  - ADDR_WE → ADDR_GAP after `WE_CYCLES`.
  - ADDR_GAP → DATA_WE after `GAP_CYCLES`.
  - DATA_WE → DATA_GAP after `WE_CYCLES`.
  - DATA_GAP → IDLE after `GAP_CYCLES`.
- **Bus values by phase:**
  - ADDR_WE / ADDR_GAP: `opl_addr = {index[8], 0}`, `opl_din = index[7:0]`.
  - DATA_WE / DATA_GAP: `opl_addr = {index[8], 1}`, `opl_din = data`.
  - `opl_we = 1` only in ADDR_WE and DATA_WE.
  - In IDLE, `opl_addr`/`opl_din` keep their last values and `opl_we = 0`.
- **Phase counter:** one down-counter, 8 bits wide. It loads `N-1` on entry to each timed state and advances the state when it reads 0.
- **No back-to-back overlap:** IDLE lasts at least one cycle between transactions, because acceptance happens only in IDLE.
- **Reset:** while `rst_n = 0` (asynchronous), outputs are `opl_we = 0`, `opl_addr = 0`, `opl_din = 0`, both `ready = 0`, `busy = 0`, `last_grant = 1`, state IDLE.
- **Reset mid-transaction:** the transaction is abandoned and no replay occurs. The requester already saw `ready`, so the loss is owned by the system reset.
- **Parameter checks:** out-of-range parameters are flagged by an elaboration-time `$error`.

## Timing
- Accept in cycle T; `opl_we` rises at T+1 (registered output).
- Index phase: `opl_we` high in cycles T+1 … T+WE_CYCLES, then low for `GAP_CYCLES`.
- Data phase: `opl_we` rises at T+1+WE_CYCLES+GAP_CYCLES.
- `busy` is high from T+1 to T+2·(WE_CYCLES+GAP_CYCLES) inclusive.
- Earliest next accept is the cycle after `busy` falls: transaction period is 2·(W+G)+1 cycles, which is 25 with default parameters.
- `opl_addr`/`opl_din` change only on the cycle entering ADDR_WE or DATA_WE. They are never changed in the same cycle as an `opl_we` edge other than that rising edge.
- Simultaneous valid on both requesters in IDLE: exactly one `ready` pulses; the loser stays pending and is served in the next IDLE cycle.

## Structure
- Package `opl3_seq_pkg`:
  - `seq_state_t` enum (IDLE, ADDR_WE, ADDR_GAP, DATA_WE, DATA_GAP).
  - `OPL_A0_INDEX = 1'b0`, `OPL_A0_DATA = 1'b1` constants.
  - Parameter-range limit constants.
- Sub-module `opl3_rr_arb2`: combinational 2-way round-robin winner select from (`valid0`, `valid1`, `last_grant`), plus the registered `last_grant` update on accept.

## Test plan
- **Single write:** `req0` with index 0x0A4, data 0x57, default parameters.
  - `ready` at T.
  - `opl_we` high T+1..T+4 with `addr = 0`, `din = 0xA4`.
  - `opl_we` high T+13..T+16 with `addr = 1`, `din = 0x57`.
  - `busy` falls after T+24.
- **Bank select:** index 0x105, data 0x01 → both phases have `opl_addr[1] = 1`; `din` is 0x05, then 0x01.
- **Tie and round-robin:** both valid continuously from reset.
  - Grants alternate 0, 1, 0, 1.
  - `last_grant` toggles on each accept.
  - Accept spacing is 25 cycles.
- **Input stability:** change `req0_data` to 0xFF after `ready` → `opl_din` in the data phase still shows the captured value.
- **Reset mid-operation:** assert `rst_n = 0` during DATA_WE.
  - `opl_we`, `opl_addr`, `opl_din` go to 0 asynchronously; `busy` = 0.
  - After release, the next pending request is accepted within 2 cycles, with requester 0 favoured.
- **Parameter corner:** `WE_CYCLES = 1`, `GAP_CYCLES = 2` → `opl_we` is a 1-cycle pulse per phase, the period is 7 cycles, and the OPL3 timer preset write at index 2 lands correctly.
